// File: rtl/mda_pwm_capture.sv
// PWM capture: measures period (cycle count minus 1) and high time of an asynchronous
// input in clock cycles, flagging a timeout when the input stops toggling.
module mda_pwm_capture #(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             pwm_in,
    output logic [WIDTH-1:0] period,
    output logic [WIDTH-1:0] duty_cycle,
    output logic             valid,
    output logic             timeout,
    output logic             stuck_level
);

    typedef enum logic [1:0] {
        SYNC_LOW,
        WAIT_RISE,
        HIGH,
        LOW
    } state_t;

    localparam logic [WIDTH-1:0] CNT_MAX = '1;
    localparam logic [WIDTH-1:0] SETTLE  = WIDTH'(SYNC_STAGES);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev;
    logic                   s;
    logic                   rise;
    logic                   fall;
    logic                   sat;
    logic [WIDTH-1:0]       cnt;
    logic [WIDTH-1:0]       cnt_next;
    logic [WIDTH-1:0]       duty_shadow;
    state_t                 state;

    assign s        = sync_q[SYNC_STAGES-1];
    assign rise     = s & ~prev;
    assign fall     = ~s & prev;
    assign sat      = (cnt == CNT_MAX);
    assign cnt_next = sat ? cnt : cnt + 1'b1;

    // NOTE: non-blocking assignments in every clocked block so all flops see pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
            prev   <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
            prev   <= s;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= SYNC_LOW;
            cnt         <= '0;
            duty_shadow <= '0;
            period      <= '0;
            duty_cycle  <= '0;
            valid       <= 1'b0;
            timeout     <= 1'b0;
            stuck_level <= 1'b0;
        end else if (!enable) begin
            state       <= SYNC_LOW;
            cnt         <= '0;
            duty_shadow <= '0;
            valid       <= 1'b0;
        end else begin
            // NOTE: valid defaults low every cycle so it is a single-cycle registered pulse.
            valid <= 1'b0;
            cnt   <= cnt_next;
            unique case (state)
                // cnt counts edges since the clear; s only reflects real pin samples
                // once the synchronizer has refilled, so an input held high is never
                // mistaken for a fresh rising edge.
                SYNC_LOW: begin
                    if (!s && (cnt >= SETTLE)) state <= WAIT_RISE;
                end
                WAIT_RISE: begin
                    if (rise) begin
                        cnt   <= WIDTH'(1);
                        state <= HIGH;
                    end
                end
                HIGH: begin
                    if (fall) begin
                        duty_shadow <= cnt;
                        state       <= LOW;
                    end else if (sat) begin
                        timeout     <= 1'b1;
                        stuck_level <= 1'b1;
                        state       <= SYNC_LOW;
                    end
                end
                LOW: begin
                    if (rise) begin
                        period     <= cnt - WIDTH'(1);
                        duty_cycle <= duty_shadow;
                        valid      <= 1'b1;
                        timeout    <= 1'b0;
                        cnt        <= WIDTH'(1);
                        state      <= HIGH;
                    end else if (sat) begin
                        timeout     <= 1'b1;
                        stuck_level <= 1'b0;
                        state       <= SYNC_LOW;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mda_pwm_capture.sv
// Bench for mda_pwm_capture: a 16-bit and an 8-bit instance share one stimulus and are
// compared every cycle against an edge-timestamp model, plus hand-computed spot checks.
module tb_mda_pwm_capture;

    localparam int PH_IDLE  = 0;
    localparam int PH_ARMED = 1;
    localparam int PH_HIGH  = 2;
    localparam int PH_LOW   = 3;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        pwm_in;
    logic [15:0] period16;
    logic [15:0] duty16;
    logic        valid16;
    logic        timeout16;
    logic        stuck16;
    logic [7:0]  period8;
    logic [7:0]  duty8;
    logic        valid8;
    logic        timeout8;
    logic        stuck8;

    int n_checks = 0;
    int n_pass   = 0;

    mda_pwm_capture #(.WIDTH(16), .SYNC_STAGES(2)) dut16 (
        .clk(clk), .reset(reset), .enable(enable), .pwm_in(pwm_in),
        .period(period16), .duty_cycle(duty16), .valid(valid16),
        .timeout(timeout16), .stuck_level(stuck16)
    );

    mda_pwm_capture #(.WIDTH(8), .SYNC_STAGES(2)) dut8 (
        .clk(clk), .reset(reset), .enable(enable), .pwm_in(pwm_in),
        .period(period8), .duty_cycle(duty8), .valid(valid8),
        .timeout(timeout8), .stuck_level(stuck8)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    function automatic int max_cnt(input int i);
        return (i == 0) ? 65535 : 255;
    endfunction

    // ---------------- model: works on pin-edge timestamps, not counters ----------------
    bit smp_pin = 1'b0;
    bit smp_rst = 1'b1;
    bit smp_en  = 1'b1;
    bit ph[0:2];            // ph[k] = pin sampled k+1 edges before the current one
    int edge_n = 0;
    int m_phase[2];
    int m_since[2];
    int m_rise_t[2];
    int m_fall_t[2];
    int e_period[2];
    int e_duty[2];
    int e_valid[2];
    int e_timeout[2];
    int e_stuck[2];

    always @(posedge clk) begin
        smp_pin <= pwm_in;
        smp_rst <= reset;
        smp_en  <= enable;
    end

    always @(negedge clk) begin
        bit s_v, p_v, r, f;
        edge_n++;
        s_v = ph[1];
        p_v = ph[2];
        r   = s_v & ~p_v;
        f   = ~s_v & p_v;
        for (int i = 0; i < 2; i++) begin
            e_valid[i] = 0;
            if (smp_rst) begin
                m_phase[i] = PH_IDLE; m_since[i] = 0;
                e_period[i] = 0; e_duty[i] = 0; e_timeout[i] = 0; e_stuck[i] = 0;
            end else if (!smp_en) begin
                m_phase[i] = PH_IDLE; m_since[i] = 0;
            end else begin
                case (m_phase[i])
                    PH_IDLE: begin
                        if (!s_v && m_since[i] >= 2) m_phase[i] = PH_ARMED;
                        if (m_since[i] < 1000) m_since[i]++;
                    end
                    PH_ARMED: begin
                        if (r) begin m_rise_t[i] = edge_n; m_phase[i] = PH_HIGH; end
                    end
                    PH_HIGH: begin
                        if (f) begin
                            m_fall_t[i] = edge_n; m_phase[i] = PH_LOW;
                        end else if (edge_n - m_rise_t[i] >= max_cnt(i)) begin
                            e_timeout[i] = 1; e_stuck[i] = 1;
                            m_phase[i] = PH_IDLE; m_since[i] = 1000;
                        end
                    end
                    default: begin
                        if (r) begin
                            e_period[i] = edge_n - m_rise_t[i] - 1;
                            e_duty[i]   = m_fall_t[i] - m_rise_t[i];
                            e_valid[i]  = 1; e_timeout[i] = 0;
                            m_rise_t[i] = edge_n; m_phase[i] = PH_HIGH;
                        end else if (edge_n - m_rise_t[i] >= max_cnt(i)) begin
                            e_timeout[i] = 1; e_stuck[i] = 0;
                            m_phase[i] = PH_IDLE; m_since[i] = 1000;
                        end
                    end
                endcase
            end
        end
        if (smp_rst) begin
            ph[0] = 1'b0; ph[1] = 1'b0; ph[2] = 1'b0;
        end else begin
            ph[2] = ph[1]; ph[1] = ph[0]; ph[0] = smp_pin;
        end
        check("model valid16",   int'(valid16),   e_valid[0]);
        check("model period16",  int'(period16),  e_period[0]);
        check("model duty16",    int'(duty16),    e_duty[0]);
        check("model timeout16", int'(timeout16), e_timeout[0]);
        check("model stuck16",   int'(stuck16),   e_stuck[0]);
        check("model valid8",    int'(valid8),    e_valid[1]);
        check("model period8",   int'(period8),   e_period[1]);
        check("model duty8",     int'(duty8),     e_duty[1]);
        check("model timeout8",  int'(timeout8),  e_timeout[1]);
        check("model stuck8",    int'(stuck8),    e_stuck[1]);
    end

    // ---------------- stimulus ----------------
    task automatic hold(input bit v, input int n);
        pwm_in = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic pwm(input int per, input int hi, input int n);
        for (int k = 0; k < n; k++) begin
            hold(1'b1, hi);
            hold(1'b0, per - hi);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " period16"},  int'(period16),  0);
        check({tag, " duty16"},    int'(duty16),    0);
        check({tag, " valid16"},   int'(valid16),   0);
        check({tag, " timeout16"}, int'(timeout16), 0);
        check({tag, " stuck16"},   int'(stuck16),   0);
        check({tag, " period8"},   int'(period8),   0);
        check({tag, " timeout8"},  int'(timeout8),  0);
    endtask

    initial begin
        reset  = 1'b1;
        enable = 1'b1;
        pwm_in = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;
        hold(1'b0, 10);

        // 100/30: first rise only arms; second rise reports three clocks after the pin rise
        pwm(100, 30, 1);
        pwm_in = 1'b1;
        @(negedge clk); check("lat valid16 +1", int'(valid16), 0);
        @(negedge clk); check("lat valid16 +2", int'(valid16), 0);
        @(negedge clk);
        check("lat valid16 +3", int'(valid16), 1);
        check("first period16", int'(period16), 99);
        check("first duty16",   int'(duty16),   30);
        check("first valid8",   int'(valid8),   1);
        hold(1'b1, 27);
        hold(1'b0, 70);
        pwm(100, 30, 3);

        // minimum waveform, then nearly-always-high waveform
        pwm(2, 1, 10);
        check("min period16", int'(period16), 1);
        check("min duty16",   int'(duty16),   1);
        pwm(1000, 999, 2);
        check("long timeout8", int'(timeout8), 1);
        check("long stuck8",   int'(stuck8),   1);
        hold(1'b1, 3);
        check("long period16", int'(period16), 999);
        check("long duty16",   int'(duty16),   999);
        hold(1'b1, 27);
        hold(1'b0, 70);
        pwm(100, 30, 3);

        // stuck high: 8-bit instance times out exactly 255 edges after the registered rise
        pwm_in = 1'b1;
        repeat (257) @(negedge clk);
        check("stuck timeout8 early", int'(timeout8), 0);
        @(negedge clk);
        check("stuck timeout8",  int'(timeout8),  1);
        check("stuck level8",    int'(stuck8),    1);
        check("stuck period8",   int'(period8),   99);
        check("stuck duty8",     int'(duty8),     30);
        check("stuck timeout16", int'(timeout16), 0);
        repeat (142) @(negedge clk);
        pwm(50, 20, 3);
        check("resume period8",  int'(period8),  49);
        check("resume duty8",    int'(duty8),    20);
        check("resume timeout8", int'(timeout8), 0);

        // input held high through reset release
        pwm_in = 1'b1;
        reset  = 1'b1;
        repeat (4) @(negedge clk);
        check_all_zero("reset high");
        reset = 1'b0;
        hold(1'b1, 20);
        pwm(50, 20, 3);
        check("post-reset period16", int'(period16), 49);
        check("post-reset duty16",   int'(duty16),   20);

        // reset mid-HIGH
        hold(1'b1, 10);
        reset = 1'b1;
        @(negedge clk);
        check_all_zero("reset mid-high");
        reset = 1'b0;
        hold(1'b1, 10);
        hold(1'b0, 30);
        pwm(50, 20, 3);

        // enable dropped mid-LOW
        pwm(100, 30, 2);
        hold(1'b1, 30);
        hold(1'b0, 10);
        enable = 1'b0;
        hold(1'b0, 10);
        check("disabled period16", int'(period16), 99);
        check("disabled valid16",  int'(valid16),  0);
        enable = 1'b1;
        hold(1'b0, 50);
        pwm(100, 30, 3);
        check("restart period16", int'(period16), 99);
        check("restart duty16",   int'(duty16),   30);
        hold(1'b0, 5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
